fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised next-generation instruction fetch stage for the debug core: PC register, inferred instruction memory with UART programming port, and a prefetch queue decoupling fetch from the ID stage.
- Sits between the UART loader/hazard unit and if_id_reg.
- Adds a multi-entry buffer, a valid/stall handshake, flush-on-redirect with in-flight discard, and a selectable redirect mode.

Parameters:
- ISA_WIDTH, 32, instruction and PC width in bits.
- ROM_DEPTH, 14, word-address bits; memory holds 2^ROM_DEPTH words.
- FIFO_DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 0, PC loaded on reset and on reset-kind redirect.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- uart_disable  in  1  0 = UART programming active, fetch halted; 1 = normal fetch.
- uart_write_enable  in  1  UART write strobe.
- uart_data  in  ISA_WIDTH  UART write data.
- uart_addr  in  ROM_DEPTH+1  UART word address; MSB=1 targets data memory and is ignored here.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_kind  in  2  00 offset, 01 absolute, 10 reset to RESET_PC, 11 reserved.
- redirect_base  in  ISA_WIDTH  base PC for offset redirect.
- redirect_value  in  ISA_WIDTH  word offset (kind 00) or absolute byte target (kind 01).
- stall  in  1  consumer not ready; head is held.
- out_valid  out  1  queue head valid.
- out_instruction  out  ISA_WIDTH  head instruction.
- out_pc  out  ISA_WIDTH  PC of head instruction.
- fetch_pc  out  ISA_WIDTH  next PC to be issued.
- queue_count  out  clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Reset (asynchronous, any time, including mid-fetch):
  - queue emptied, in-flight flag cleared, fetch_pc = RESET_PC.
  - out_valid = 0, out_instruction = 0, out_pc = 0, queue_count = 0.
  - Memory contents are preserved.
- Memory:
  - Synchronous read with one-edge latency; read address is fetch_pc[ROM_DEPTH+1:2], so addresses beyond memory wrap modulo 2^ROM_DEPTH.
  - PC low two bits are kept in the PC value but ignored for addressing.
- UART mode (uart_disable = 0):
  - No reads issued; queue and in-flight flag are flushed every cycle; fetch_pc is held.
  - Memory write at uart_addr[ROM_DEPTH-1:0] when uart_write_enable = 1 and uart_addr[ROM_DEPTH] = 0.
  - Redirects are ignored in this mode.
- Issue rule:
  - A read issues at an edge when uart_disable = 1, redirect_valid = 0, and queue_count + inflight (post-pop) < FIFO_DEPTH.
  - On issue: fetch_pc += 4 (mod 2^ISA_WIDTH), inflight = 1, and the issued PC is tagged.
- Response: at the next edge the returned word and its tagged PC are pushed; out_valid rises after that edge.
- Handshake:
  - An entry is consumed at an edge when out_valid = 1 and stall = 0.
  - Head outputs remain stable while stall = 1.
  - Push and pop in the same cycle are legal at any occupancy, including full.
- Full / empty:
  - The issue gate guarantees a push is never dropped.
  - When empty, out_valid = 0 and out_instruction/out_pc read 0.
- Redirect (redirect_valid = 1, kind != 11, uart_disable = 1):
  - Queue flushed and any in-flight response discarded; no read in that cycle.
  - Stall does not block a redirect.
  - Target by kind:
    - 00: redirect_base + (redirect_value << 2), mod 2^ISA_WIDTH.
    - 01: redirect_value.
    - 10: RESET_PC.
  - Kind 11 is ignored entirely.
- Redirect latency: redirect sampled at edge E0 → target issued at E1 → pushed at E2 → out_valid = 1 after E2.
- Reset-to-first-instruction latency: the same two edges (issue, then push).

Optional Feature:
- Macro: FETCH_BREAKPOINT_EN.
- With the macro defined:
  - Adds ports bp_enable (in, 1), bp_addr (in, ISA_WIDTH), bp_resume (in, 1) and bp_hit (out, 1, reset 0).
  - When bp_enable = 1 and the valid head has out_pc == bp_addr, out_valid is forced to 0 and bp_hit = 1; prefetch continues until the queue is full.
  - A bp_resume pulse releases that one head entry: it is presented once, and the hit re-arms for the next match.
  - A redirect or reset clears bp_hit.
- Without the macro: the ports are absent and out_valid is never masked.

Test Plan:
- Load words 0x11,0x22,0x33,0x44,0x55 via UART at addresses 0..4, then uart_disable = 1 with stall = 0 → out_pc 0,4,8,12,16 and matching instructions; first out_valid two edges after reset release.
- stall = 1 for 10 cycles, FIFO_DEPTH = 4 → queue_count saturates at 4; head stays 0x11/pc 0; no entry is lost after release.
- Offset redirect with base 0x10 and value 0xFFFFFFFE while the queue holds 3 entries → queue emptied next cycle; next out_pc = 0x08; no stale word appears.
- Absolute redirect to 0x40 in the same cycle as the response arrives for pc 0x0C → 0x0C is discarded; out_pc 0x40 arrives two edges later.
- rst_n asserted while full and stalled → out_valid = 0 and queue_count = 0 immediately; restart at RESET_PC.
- With FETCH_BREAKPOINT_EN, bp_addr = 0x08 → bp_hit = 1 with out_valid = 0 at pc 0x08; after a bp_resume pulse, 0x08 is consumed and fetch continues with 0x0C.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC register, UART-loadable instruction memory and prefetch queue feeding ID.
// Defining FETCH_BREAKPOINT_EN adds a breakpoint that holds a matching queue head.
module fetch_queue_unit #(
  parameter int ISA_WIDTH = 32,
  parameter int ROM_DEPTH = 14,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ISA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         uart_disable,
  input  logic                         uart_write_enable,
  input  logic [ISA_WIDTH-1:0]         uart_data,
  input  logic [ROM_DEPTH:0]           uart_addr,
  input  logic                         redirect_valid,
  input  logic [1:0]                   redirect_kind,
  input  logic [ISA_WIDTH-1:0]         redirect_base,
  input  logic [ISA_WIDTH-1:0]         redirect_value,
  input  logic                         stall,
  output logic                         out_valid,
  output logic [ISA_WIDTH-1:0]         out_instruction,
  output logic [ISA_WIDTH-1:0]         out_pc,
  output logic [ISA_WIDTH-1:0]         fetch_pc,
  output logic [$clog2(FIFO_DEPTH):0]  queue_count
`ifdef FETCH_BREAKPOINT_EN
  ,
  input  logic                         bp_enable,
  input  logic [ISA_WIDTH-1:0]         bp_addr,
  input  logic                         bp_resume,
  output logic                         bp_hit
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  logic [ISA_WIDTH-1:0] mem [2**ROM_DEPTH];
  logic [ISA_WIDTH-1:0] ins_q [FIFO_DEPTH];
  logic [ISA_WIDTH-1:0] pcs_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d, occ;
  logic [ISA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, tag_q, rdata_q, target;
  logic inflight_q, redirect, flush, pop, push, issue, nonempty;
  assign redirect = uart_disable && redirect_valid && redirect_kind != 2'b11;
  assign flush = !uart_disable || redirect;
  assign nonempty = count_q != '0;
  assign pop = out_valid && !stall;
  assign push = inflight_q && !flush;
  // occupancy after this edge's pop and the in-flight push; gates the next read
  assign occ = count_q - CW'(pop) + CW'(inflight_q);
  assign issue = !flush && occ < DEPTH;
  assign count_d = flush ? '0 : count_q - CW'(pop) + CW'(push);
  assign target = redirect_kind == 2'b00 ? redirect_base + (redirect_value << 2) :
                  redirect_kind == 2'b01 ? redirect_value : RESET_PC;
  assign fetch_pc_d = redirect ? target : issue ? fetch_pc_q + ISA_WIDTH'(4) : fetch_pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q <= '0;
    end else begin
      count_q <= count_d;
      rd_q <= flush ? '0 : rd_q + PW'(pop);
      wr_q <= flush ? '0 : wr_q + PW'(push);
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      tag_q <= issue ? fetch_pc_q : tag_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!uart_disable && uart_write_enable && !uart_addr[ROM_DEPTH])
      mem[uart_addr[ROM_DEPTH-1:0]] <= uart_data;
    if (issue)
      rdata_q <= mem[fetch_pc_q[ROM_DEPTH+1:2]];
  end
  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wr_q] <= rdata_q;
      pcs_q[wr_q] <= tag_q;
    end
  end
  assign out_instruction = nonempty ? ins_q[rd_q] : '0;
  assign out_pc = nonempty ? pcs_q[rd_q] : '0;
  assign fetch_pc = fetch_pc_q;
  assign queue_count = count_q;
`ifdef FETCH_BREAKPOINT_EN
  logic rel_q, hold;
  // rel_q lets exactly one matching head through after a resume pulse
  assign hold = bp_enable && nonempty && pcs_q[rd_q] == bp_addr && !rel_q;
  assign out_valid = nonempty && !hold;
  assign bp_hit = hold;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rel_q <= 1'b0;
    else
      rel_q <= (flush || pop) ? 1'b0 : (bp_resume && hold) ? 1'b1 : rel_q;
  end
`else
  assign out_valid = nonempty;
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed vector table, corner sequences and a random run against a queue model.
module tb_fetch_queue_unit;
  localparam int RD = 6;
  logic clk = 1'b0;
  logic rst_n, uart_disable, uart_write_enable, redirect_valid, stall;
  logic [31:0] uart_data, redirect_base, redirect_value;
  logic [RD:0] uart_addr;
  logic [1:0] redirect_kind;
  logic out_valid;
  logic [31:0] out_instruction, out_pc, fetch_pc;
  logic [2:0] queue_count;
`ifdef FETCH_BREAKPOINT_EN
  logic bp_enable = 1'b0, bp_resume = 1'b0, bp_hit;
  logic [31:0] bp_addr = '0;
`endif
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fetch_queue_unit #(.ROM_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .uart_disable(uart_disable),
    .uart_write_enable(uart_write_enable), .uart_data(uart_data), .uart_addr(uart_addr),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .redirect_base(redirect_base), .redirect_value(redirect_value), .stall(stall),
    .out_valid(out_valid), .out_instruction(out_instruction), .out_pc(out_pc),
    .fetch_pc(fetch_pc), .queue_count(queue_count)
`ifdef FETCH_BREAKPOINT_EN
    , .bp_enable(bp_enable), .bp_addr(bp_addr), .bp_resume(bp_resume), .bp_hit(bp_hit)
`endif
  );

  typedef struct {
    logic rst_n, ud, st, rv;
    logic [1:0] kind;
    logic [31:0] base, val;
    logic ev;
    logic [31:0] ei, ep;
    logic [2:0] ec;
    logic [31:0] ef;
  } vec_t;
  vec_t tbl[$];

  // reference model: plain queues and a word array
  logic [31:0] m_mem [2**RD];
  logic [31:0] q_pc[$], q_ins[$];
  logic [31:0] m_fpc, m_tag;
  bit m_inf;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic ev, logic [31:0] ei, logic [31:0] ep, logic [2:0] ec, logic [31:0] ef);
    chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, "_instr"}, out_instruction, ei);
    chk({tag, "_pc"}, out_pc, ep);
    chk({tag, "_count"}, 32'(queue_count), 32'(ec));
    chk({tag, "_fetch_pc"}, fetch_pc, ef);
  endtask

  function automatic void v(logic r, logic ud, logic st, logic rv, logic [1:0] k, logic [31:0] b,
                            logic [31:0] va, logic ev, logic [31:0] ei, logic [31:0] ep,
                            logic [2:0] ec, logic [31:0] ef);
    tbl.push_back('{r, ud, st, rv, k, b, va, ev, ei, ep, ec, ef});
  endfunction

  function automatic void model_reset();
    q_pc.delete();
    q_ins.delete();
    m_fpc = 0;
    m_tag = 0;
    m_inf = 0;
  endfunction

  function automatic void model_step();
    bit pop = q_pc.size() != 0 && !stall;
    if (!uart_disable) begin
      if (uart_write_enable && !uart_addr[RD]) m_mem[uart_addr[RD-1:0]] = uart_data;
      q_pc.delete();
      q_ins.delete();
      m_inf = 0;
    end else if (redirect_valid && redirect_kind != 2'b11) begin
      q_pc.delete();
      q_ins.delete();
      m_inf = 0;
      m_fpc = redirect_kind == 2'b00 ? redirect_base + redirect_value * 4 :
              redirect_kind == 2'b01 ? redirect_value : 32'h0;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (m_inf) begin
        q_pc.push_back(m_tag);
        q_ins.push_back(m_mem[(m_tag / 4) % (2**RD)]);
      end
      m_inf = q_pc.size() < 4;
      if (m_inf) begin
        m_tag = m_fpc;
        m_fpc = m_fpc + 4;
      end
    end
  endfunction

  initial begin
    rst_n = 1'b0; uart_disable = 1'b0; uart_write_enable = 1'b0; uart_data = '0; uart_addr = '0;
    redirect_valid = 1'b0; redirect_kind = '0; redirect_base = '0; redirect_value = '0; stall = 1'b0;
    #1;
    chk_all("reset_async", 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2**RD; i++) begin
      uart_write_enable = 1'b1;
      uart_addr = 7'(i);
      uart_data = 32'h11 * (i + 1);
      m_mem[i] = uart_data;
      @(negedge clk);
    end
    uart_addr = 7'h40;
    uart_data = 32'hDEAD_BEEF;
    @(negedge clk);
    uart_write_enable = 1'b0;

    v(0,1,0,0,0,0,0,          0,0,0,0,0);
    v(1,1,0,0,0,0,0,          0,0,0,0,4);
    v(1,1,0,0,0,0,0,          1,32'h11,0,1,8);
    v(1,1,0,0,0,0,0,          1,32'h22,4,1,12);
    v(1,1,0,0,0,0,0,          1,32'h33,8,1,16);
    v(1,1,0,0,0,0,0,          1,32'h44,12,1,20);
    v(1,1,0,0,0,0,0,          1,32'h55,16,1,24);
    v(0,1,1,0,0,0,0,          0,0,0,0,0);
    v(1,1,1,0,0,0,0,          0,0,0,0,4);
    v(1,1,1,0,0,0,0,          1,32'h11,0,1,8);
    v(1,1,1,0,0,0,0,          1,32'h11,0,2,12);
    v(1,1,1,0,0,0,0,          1,32'h11,0,3,16);
    for (int i = 0; i < 6; i++) v(1,1,1,0,0,0,0, 1,32'h11,0,4,16);
    v(1,1,0,0,0,0,0,          1,32'h22,4,3,20);
    v(1,1,0,0,0,0,0,          1,32'h33,8,3,24);
    v(1,1,0,0,0,0,0,          1,32'h44,12,3,28);
    v(1,1,0,0,0,0,0,          1,32'h55,16,3,32);
    v(1,1,1,1,0,32'h10,32'hFFFF_FFFE, 0,0,0,0,8);
    v(1,1,0,0,0,0,0,          0,0,0,0,12);
    v(1,1,0,0,0,0,0,          1,32'h33,8,1,16);
    v(1,1,0,1,1,0,32'h40,     0,0,0,0,32'h40);
    v(1,1,0,0,0,0,0,          0,0,0,0,32'h44);
    v(1,1,0,0,0,0,0,          1,32'h121,32'h40,1,32'h48);
    v(1,1,0,1,3,0,32'h80,     1,32'h132,32'h44,1,32'h4C);
    v(1,1,0,1,2,0,32'h80,     0,0,0,0,0);
    v(1,1,0,0,0,0,0,          0,0,0,0,4);
    v(1,1,0,0,0,0,0,          1,32'h11,0,1,8);
    v(1,0,0,0,0,0,0,          0,0,0,0,8);
    v(1,0,0,1,1,0,32'h80,     0,0,0,0,8);
    v(1,1,0,0,0,0,0,          0,0,0,0,12);
    v(1,1,0,0,0,0,0,          1,32'h33,8,1,16);
    v(1,1,0,1,1,0,32'h100,    0,0,0,0,32'h100);
    v(1,1,0,0,0,0,0,          0,0,0,0,32'h104);
    v(1,1,0,0,0,0,0,          1,32'h11,32'h100,1,32'h108);
    v(1,1,0,1,1,0,32'hFFFF_FFFC, 0,0,0,0,32'hFFFF_FFFC);
    v(1,1,0,0,0,0,0,          0,0,0,0,0);
    v(1,1,0,0,0,0,0,          1,32'h440,32'hFFFF_FFFC,1,4);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; uart_disable = tbl[i].ud; stall = tbl[i].st;
      redirect_valid = tbl[i].rv; redirect_kind = tbl[i].kind;
      redirect_base = tbl[i].base; redirect_value = tbl[i].val;
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].ec, tbl[i].ef);
    end

    // async reset while full and stalled
    redirect_valid = 1'b0; stall = 1'b1;
    repeat (8) @(negedge clk);
    chk("full_count", 32'(queue_count), 4);
    chk("full_head_pc", out_pc, 32'hFFFF_FFFC);
    #2 rst_n = 1'b0;
    #1;
    chk_all("midcycle_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    @(negedge clk);
    chk_all("restart_e1", 0, 0, 0, 0, 4);
    @(negedge clk);
    chk_all("restart_e2", 1, 32'h11, 0, 1, 8);

    // random run against the model
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      chk_all("rnd", q_pc.size() != 0, q_pc.size() ? q_ins[0] : 32'h0,
              q_pc.size() ? q_pc[0] : 32'h0, 3'(q_pc.size()), m_fpc);
      uart_disable = $urandom_range(0, 19) != 0;
      uart_write_enable = 1'($urandom);
      uart_addr = 7'($urandom);
      uart_data = $urandom;
      redirect_valid = $urandom_range(0, 9) == 0;
      redirect_kind = 2'($urandom);
      redirect_base = $urandom;
      redirect_value = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 80));
      stall = $urandom_range(0, 2) == 0;
      model_step();
      @(negedge clk);
    end

`ifdef FETCH_BREAKPOINT_EN
    uart_disable = 1'b1; uart_write_enable = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    bp_enable = 1'b1; bp_addr = 32'h8;
    rst_n = 1'b0;
    @(negedge clk);
    chk("bp_reset_hit", 32'(bp_hit), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("bp_hold_valid", 32'(out_valid), 0);
    chk("bp_hold_hit", 32'(bp_hit), 1);
    chk("bp_hold_pc", out_pc, 8);
    repeat (3) @(negedge clk);
    chk("bp_prefetch_full", 32'(queue_count), 4);
    chk("bp_still_pc", out_pc, 8);
    bp_resume = 1'b1;
    @(negedge clk);
    bp_resume = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 1);
    chk("bp_release_hit", 32'(bp_hit), 0);
    chk("bp_release_pc", out_pc, 8);
    @(negedge clk);
    chk("bp_next_pc", out_pc, 32'hC);
    chk("bp_next_valid", 32'(out_valid), 1);
    bp_enable = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
